// File: rtl/axi_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_engine_pkg
//  Description : Shared AXI read-engine types, response codes and AR constants
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_engine_pkg;

    localparam logic [1:0] c_resp_okay    = 2'b00;
    localparam logic [1:0] c_resp_exokay  = 2'b01;
    localparam logic [1:0] c_resp_slverr  = 2'b10;
    localparam logic [1:0] c_resp_decerr  = 2'b11;

    localparam logic [1:0] c_arburst_incr = 2'b01;
    localparam logic       c_arlock       = 1'b0;
    localparam logic [3:0] c_arcache      = 4'b0011;
    localparam logic [2:0] c_arprot       = 3'b010;
    localparam logic [3:0] c_arqos        = 4'b0000;
    localparam logic [3:0] c_arregion     = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } engine_state_t;

    function automatic logic [2:0] arsize_from_width(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_outstanding_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : rd_outstanding_ctr
//  Description : Saturating up/down counter of in-flight read bursts
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_outstanding_ctr #(
    parameter int MAX_COUNT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty
);

    localparam int                 c_cnt_w = $clog2(MAX_COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_COUNT);

    logic [c_cnt_w-1:0] r_count;
    logic               w_up;
    logic               w_down;

    // Simultaneous inc and dec cancel; stray decrements at zero are dropped.
    assign w_up   = i_inc && !i_dec && (r_count != c_max);
    assign w_down = i_dec && !i_inc && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (w_up) begin
            r_count <= r_count + 1'b1;
        end else if (w_down) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_full  = (r_count == c_max);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rd_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rd_burst_engine
//  Description : Strided AXI4 read-burst engine with bounded outstanding ARs
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_burst_engine
    import axi_engine_pkg::*;
#(
    parameter int ENGINE_ID       = 0,
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 256,
    parameter int ID_WIDTH        = 6,
    parameter int LEN_WIDTH       = 8,
    parameter int CNT_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  burst,
    input  logic [CNT_WIDTH-1:0]  num_bursts,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic                  m_axi_ARVALID,
    input  logic                  m_axi_ARREADY,
    output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
    output logic [ID_WIDTH-1:0]   m_axi_ARID,
    output logic [LEN_WIDTH-1:0]  m_axi_ARLEN,
    output logic [2:0]            m_axi_ARSIZE,
    output logic [1:0]            m_axi_ARBURST,
    output logic                  m_axi_ARLOCK,
    output logic [3:0]            m_axi_ARCACHE,
    output logic [2:0]            m_axi_ARPROT,
    output logic [3:0]            m_axi_ARQOS,
    output logic [3:0]            m_axi_ARREGION,
    input  logic                  m_axi_RVALID,
    input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
    input  logic                  m_axi_RLAST,
    input  logic [ID_WIDTH-1:0]   m_axi_RID,
    input  logic [1:0]            m_axi_RRESP,
    output logic                  m_axi_RREADY
);

    localparam logic [ID_WIDTH-1:0] c_engine_id = ID_WIDTH'(ENGINE_ID);

    engine_state_t         r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_beat_count;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_valid;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [LEN_WIDTH-1:0]  r_arlen;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [CNT_WIDTH-1:0]  r_num;
    logic [CNT_WIDTH-1:0]  r_issued;

    logic w_ar_hs;
    logic w_r_hs;
    logic w_rlast_hs;
    logic w_bad_beat;
    logic w_full;
    logic w_empty;

    assign w_ar_hs    = r_arvalid && m_axi_ARREADY;
    assign w_r_hs     = m_axi_RVALID && r_busy;
    assign w_rlast_hs = w_r_hs && m_axi_RLAST;
    assign w_bad_beat = (m_axi_RRESP == c_resp_slverr) || (m_axi_RRESP == c_resp_decerr)
                        || (m_axi_RID != c_engine_id);

    rd_outstanding_ctr #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk     (clk),
        .resetn  (resetn),
        .i_inc   (w_ar_hs),
        .i_dec   (w_rlast_hs),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_beat_count <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_next_addr  <= '0;
            r_stride     <= '0;
            r_num        <= '0;
            r_issued     <= '0;
        end else begin
            r_read_valid <= w_r_hs;
            r_read_data  <= w_r_hs ? m_axi_RDATA : '0;
            r_done       <= 1'b0;
            if (w_r_hs) begin
                if (r_beat_count != '1) begin
                    r_beat_count <= r_beat_count + 1'b1;
                end
                if (w_bad_beat) begin
                    r_err <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_next_addr  <= base_addr;
                        r_stride     <= stride;
                        r_arlen      <= burst;
                        r_num        <= num_bursts;
                        r_issued     <= '0;
                        r_beat_count <= '0;
                        r_err        <= 1'b0;
                        if (num_bursts == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ISSUE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // One AR at a time; the counter is settled before the next is raised.
                    if (w_ar_hs) begin
                        r_arvalid   <= 1'b0;
                        r_issued    <= r_issued + 1'b1;
                        r_next_addr <= r_next_addr + r_stride;
                        if (r_issued == r_num - 1'b1) begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (!r_arvalid && !w_full && (r_issued < r_num)) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_next_addr;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_data      = r_read_data;
    assign read_valid     = r_read_valid;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign beat_count     = r_beat_count;
    assign m_axi_ARVALID  = r_arvalid;
    assign m_axi_ARADDR   = r_araddr;
    assign m_axi_ARLEN    = r_arlen;
    assign m_axi_ARID     = c_engine_id;
    assign m_axi_ARSIZE   = arsize_from_width(DATA_WIDTH);
    assign m_axi_ARBURST  = c_arburst_incr;
    assign m_axi_ARLOCK   = c_arlock;
    assign m_axi_ARCACHE  = c_arcache;
    assign m_axi_ARPROT   = c_arprot;
    assign m_axi_ARQOS    = c_arqos;
    assign m_axi_ARREGION = c_arregion;
    assign m_axi_RREADY   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rd_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rd_burst_engine
//  Description : Directed self-checking bench with a simple AXI read slave
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_burst_engine;

    typedef struct {
        logic [32:0] addr;
        logic [7:0]  len;
        int          ready;
    } ar_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [32:0]  base_addr = '0;
    logic [7:0]   burst = '0;
    logic [15:0]  num_bursts = '0;
    logic [32:0]  stride = '0;
    logic [255:0] read_data;
    logic         read_valid, busy, done, err;
    logic [15:0]  beat_count;
    logic         m_axi_ARVALID;
    logic         m_axi_ARREADY = 1'b1;
    logic [32:0]  m_axi_ARADDR;
    logic [5:0]   m_axi_ARID;
    logic [7:0]   m_axi_ARLEN;
    logic [2:0]   m_axi_ARSIZE;
    logic [1:0]   m_axi_ARBURST;
    logic         m_axi_ARLOCK;
    logic [3:0]   m_axi_ARCACHE;
    logic [2:0]   m_axi_ARPROT;
    logic [3:0]   m_axi_ARQOS;
    logic [3:0]   m_axi_ARREGION;
    logic         m_axi_RVALID = 1'b0;
    logic [255:0] m_axi_RDATA = '0;
    logic         m_axi_RLAST = 1'b0;
    logic [5:0]   m_axi_RID = '0;
    logic [1:0]   m_axi_RRESP = '0;
    logic         m_axi_RREADY;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int r_delay = 0;
    int err_burst = -1;
    int err_beat = -1;
    int bad_rid_burst = -1;
    ar_t ar_log[$];
    ar_t pend[$];
    int ar_before_rlast, ost, max_ost, rv_count, done_pulses, stall_cnt;
    int rlast_cyc, done_cyc, start_cyc, err_beat_cyc, err_rise_cyc;
    int lat_err = 0, data_err = 0, ar_unstable = 0;
    bit seen_rlast, r_hs;
    bit prev_hs = 0, prev_err = 0, prev_arvalid = 0, prev_arready = 0;
    logic [255:0] prev_rdata = '0;
    logic [32:0]  prev_araddr = '0;
    logic [7:0]   prev_arlen = '0;

    ar_t r_cur;
    bit  r_active = 0;
    int  r_beat = 0;
    int  r_burst_idx = 0;

    rd_burst_engine dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .burst(burst),
        .num_bursts(num_bursts), .stride(stride), .read_data(read_data),
        .read_valid(read_valid), .busy(busy), .done(done), .err(err), .beat_count(beat_count),
        .m_axi_ARVALID(m_axi_ARVALID), .m_axi_ARREADY(m_axi_ARREADY),
        .m_axi_ARADDR(m_axi_ARADDR), .m_axi_ARID(m_axi_ARID), .m_axi_ARLEN(m_axi_ARLEN),
        .m_axi_ARSIZE(m_axi_ARSIZE), .m_axi_ARBURST(m_axi_ARBURST),
        .m_axi_ARLOCK(m_axi_ARLOCK), .m_axi_ARCACHE(m_axi_ARCACHE),
        .m_axi_ARPROT(m_axi_ARPROT), .m_axi_ARQOS(m_axi_ARQOS),
        .m_axi_ARREGION(m_axi_ARREGION), .m_axi_RVALID(m_axi_RVALID),
        .m_axi_RDATA(m_axi_RDATA), .m_axi_RLAST(m_axi_RLAST), .m_axi_RID(m_axi_RID),
        .m_axi_RRESP(m_axi_RRESP), .m_axi_RREADY(m_axi_RREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Observation point: mid-cycle, so everything seen here is what the next edge acts on.
    always @(negedge clk) begin
        cyc++;
        if (m_axi_ARVALID && m_axi_ARREADY) begin
            ar_log.push_back('{m_axi_ARADDR, m_axi_ARLEN, cyc + r_delay});
            pend.push_back('{m_axi_ARADDR, m_axi_ARLEN, cyc + r_delay});
            if (!seen_rlast) ar_before_rlast++;
            ost++;
        end
        if (m_axi_ARVALID && !m_axi_ARREADY) stall_cnt++;
        if (prev_arvalid && !prev_arready &&
            (!m_axi_ARVALID || m_axi_ARADDR != prev_araddr || m_axi_ARLEN != prev_arlen))
            ar_unstable++;
        r_hs = m_axi_RVALID && m_axi_RREADY;
        if (r_hs && m_axi_RLAST) begin
            seen_rlast = 1;
            rlast_cyc  = cyc;
            ost--;
        end
        if (ost > max_ost) max_ost = ost;
        if (r_hs && m_axi_RRESP[1]) err_beat_cyc = cyc;
        if (err && !prev_err) err_rise_cyc = cyc;
        if (read_valid !== prev_hs) lat_err++;
        if (read_valid ? (read_data !== prev_rdata) : (read_data !== '0)) data_err++;
        if (read_valid) rv_count++;
        if (done) begin
            done_pulses++;
            done_cyc = cyc;
        end
        if (start) start_cyc = cyc;
        prev_hs      = r_hs;
        prev_rdata   = m_axi_RDATA;
        prev_err     = err;
        prev_arvalid = m_axi_ARVALID;
        prev_arready = m_axi_ARREADY;
        prev_araddr  = m_axi_ARADDR;
        prev_arlen   = m_axi_ARLEN;
    end

    // Read-data slave: bursts returned in order, each no earlier than its ready cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                r_active = 0;
                m_axi_RVALID = 1'b0;
                m_axi_RLAST = 1'b0;
            end else begin
                if (r_hs && r_active) begin
                    if (r_beat == int'(r_cur.len)) begin
                        r_active = 0;
                        r_burst_idx++;
                    end else begin
                        r_beat++;
                    end
                end
                if (!r_active && pend.size() > 0 && cyc >= pend[0].ready) begin
                    r_cur = pend.pop_front();
                    r_active = 1;
                    r_beat = 0;
                end
                m_axi_RVALID = r_active;
                m_axi_RLAST  = r_active && (r_beat == int'(r_cur.len));
                m_axi_RRESP  = (r_active && r_burst_idx == err_burst && r_beat == err_beat) ? 2'b10 : 2'b00;
                m_axi_RID    = (r_active && r_burst_idx == bad_rid_burst) ? 6'd1 : 6'd0;
                for (int i = 0; i < 8; i++) m_axi_RDATA[i*32 +: 32] = $urandom();
            end
        end
    end

    task automatic clear_tb();
        ar_log.delete();
        pend.delete();
        ar_before_rlast = 0; ost = 0; max_ost = 0; rv_count = 0; done_pulses = 0;
        stall_cnt = 0; seen_rlast = 0; r_burst_idx = 0;
        rlast_cyc = -100; done_cyc = -100; start_cyc = -100;
        err_beat_cyc = -100; err_rise_cyc = -100;
    endtask

    task automatic pulse_start(input logic [32:0] b, input logic [7:0] l,
                               input logic [15:0] n, input logic [32:0] s);
        @(posedge clk); #1;
        base_addr = b; burst = l; num_bursts = n; stride = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_pulses == 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", 64'(done_pulses == 0), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] addr_at(input int i);
        return (ar_log.size() > i) ? ar_log[i].addr : '1;
    endfunction

    initial begin
        int n;
        int addr_bad;
        clear_tb();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", 64'({m_axi_ARVALID, m_axi_RREADY, read_valid, busy, done, err}), 0);
        chk("rst_cnt", 64'(beat_count), 0);
        chk("rst_ar", 64'({m_axi_ARADDR, m_axi_ARLEN}), 0);
        chk("rst_rdata", 64'(read_data != '0), 0);
        chk("ar_const", 64'({m_axi_ARSIZE, m_axi_ARBURST, m_axi_ARLOCK, m_axi_ARCACHE,
                             m_axi_ARPROT, m_axi_ARQOS, m_axi_ARREGION, m_axi_ARID}),
            64'({3'd5, 2'b01, 1'b0, 4'b0011, 3'b010, 4'd0, 4'd0, 6'd0}));
        resetn = 1'b1;

        // Single burst
        pulse_start(33'h1000, 8'd7, 16'd1, 33'h0);
        wait_done(500);
        chk("single_nar", 64'(ar_log.size()), 1);
        chk("single_addr", 64'(addr_at(0)), 64'h1000);
        chk("single_len", 64'(ar_log.size() > 0 ? ar_log[0].len : 8'hff), 7);
        chk("single_rv", 64'(rv_count), 8);
        chk("single_beats", 64'(beat_count), 8);
        chk("single_done_n", 64'(done_pulses), 1);
        chk("single_done_lat", 64'(done_cyc - rlast_cyc), 2);

        // Pipelined, slow R, with an ignored start mid-job
        clear_tb();
        r_delay = 20;
        pulse_start(33'h1000, 8'd7, 16'd10, 33'h100);
        repeat (4) @(posedge clk);
        pulse_start(33'h5000, 8'd0, 16'd1, 33'h10);
        wait_done(3000);
        chk("pipe_pre_rlast", 64'(ar_before_rlast), 4);
        chk("pipe_nar", 64'(ar_log.size()), 10);
        addr_bad = 0;
        for (int k = 0; k < 10; k++) if (addr_at(k) != 33'(33'h1000 + k * 33'h100)) addr_bad++;
        chk("pipe_addrs", 64'(addr_bad), 0);
        chk("pipe_last_addr", 64'(addr_at(9)), 64'h1900);
        chk("pipe_max_ost", 64'(max_ost), 4);
        chk("pipe_beats", 64'(beat_count), 80);
        chk("pipe_rv", 64'(rv_count), 80);

        // AR back-pressure
        clear_tb();
        r_delay = 0;
        m_axi_ARREADY = 1'b0;
        pulse_start(33'h2000, 8'd0, 16'd2, 33'h40);
        n = 0;
        while (!m_axi_ARVALID && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_arvalid_to", 64'(m_axi_ARVALID), 1);
        repeat (5) @(posedge clk);
        #1;
        m_axi_ARREADY = 1'b1;
        wait_done(500);
        chk("bp_stall", 64'(stall_cnt), 5);
        chk("bp_nar", 64'(ar_log.size()), 2);
        chk("bp_addr1", 64'(addr_at(1)), 64'h2040);
        chk("bp_rv", 64'(rv_count), 2);

        // SLVERR on beat 3 of burst index 2
        clear_tb();
        err_burst = 2; err_beat = 3;
        pulse_start(33'h3000, 8'd7, 16'd3, 33'h100);
        wait_done(1000);
        err_burst = -1; err_beat = -1;
        chk("err_sticky", 64'(err), 1);
        chk("err_rise_lat", 64'(err_rise_cyc - err_beat_cyc), 1);
        chk("err_beats", 64'(beat_count), 24);

        // Zero bursts: also clears err
        clear_tb();
        pulse_start(33'h0, 8'd0, 16'd0, 33'h0);
        wait_done(20);
        chk("zero_err_clr", 64'(err), 0);
        chk("zero_done_lat", 64'(done_cyc - start_cyc), 1);
        chk("zero_nar", 64'(ar_log.size()), 0);

        // Wrong RID
        clear_tb();
        bad_rid_burst = 0;
        pulse_start(33'h4000, 8'd1, 16'd1, 33'h0);
        wait_done(200);
        bad_rid_burst = -1;
        chk("rid_err", 64'(err), 1);
        chk("rid_beats", 64'(beat_count), 2);

        // Address wrap
        clear_tb();
        pulse_start(33'h1_FFFF_FF00, 8'd0, 16'd2, 33'h100);
        wait_done(200);
        chk("wrap_addr0", 64'(addr_at(0)), 64'h1_FFFF_FF00);
        chk("wrap_addr1", 64'(addr_at(1)), 0);

        // Reset while draining
        clear_tb();
        r_delay = 20;
        pulse_start(33'h6000, 8'd3, 16'd2, 33'h40);
        n = 0;
        while (ar_log.size() < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_busy", 64'(busy), 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_flags", 64'({m_axi_ARVALID, m_axi_RREADY, read_valid, busy, done, err}), 0);
        chk("mid_rst_regs", 64'({beat_count, m_axi_ARADDR, m_axi_ARLEN}), 0);
        chk("mid_rst_rdata", 64'(read_data != '0), 0);
        @(posedge clk); #1;
        clear_tb();
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_nar", 64'(ar_log.size()), 0);
        chk("post_rst_rv", 64'(rv_count + done_pulses), 0);

        chk("rd_latency", 64'(lat_err), 0);
        chk("rd_data", 64'(data_err), 0);
        chk("ar_stable", 64'(ar_unstable), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/rd_burst_engine.md
RD_BURST_ENGINE -- requirements
Module: rd_burst_engine

Interface
REQ-001 Parameter ENGINE_ID, default 0: value driven on m_axi_ARID.
REQ-002 Parameter ADDR_WIDTH, default 33: byte address width.
REQ-003 Parameter DATA_WIDTH, default 256: data width; legal values 64/128/256/512.
REQ-004 Parameters ID_WIDTH (default 6), LEN_WIDTH (default 8), CNT_WIDTH (default 16): AXI ID width, ARLEN width, burst-count and beat-count width.
REQ-005 Parameter MAX_OUTSTANDING, default 4: maximum number of AR requests in flight (1..16).
REQ-006 clk  in  1  clock; resetn  in  1  reset, synchronous, active-low.
REQ-007 start  in  1: pulse that begins a job; base_addr  in  ADDR_WIDTH; burst  in  LEN_WIDTH (ARLEN value); num_bursts  in  CNT_WIDTH; stride  in  ADDR_WIDTH (byte increment per burst).
REQ-008 read_data  out  DATA_WIDTH; read_valid  out  1; busy  out  1; done  out  1 (pulse); err  out  1 (sticky); beat_count  out  CNT_WIDTH.
REQ-009 AXI AR ports: m_axi_ARVALID/ARADDR/ARID/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION out; ARREADY in. AXI R ports: RVALID/RDATA/RLAST/RID/RRESP in; RREADY out.

Function
REQ-010 Constant AR fields: ARSIZE = log2(DATA_WIDTH/8), ARBURST 01, ARLOCK 0, ARCACHE 0011, ARPROT 010, ARQOS 0, ARREGION 0.
REQ-011 FSM states: IDLE, ISSUE, DRAIN, DONE. busy is high in ISSUE and DRAIN.
REQ-012 IDLE -> ISSUE on start: latch base_addr, burst, num_bursts, and stride; clear beat_count and err. If num_bursts == 0, go IDLE -> DONE instead, with no AR issued.
REQ-013 start SHALL be ignored while not in IDLE.
REQ-014 ARVALID asserts only when issued < num_bursts and outstanding < MAX_OUTSTANDING.
REQ-015 Once ARVALID is asserted, ARVALID, ARADDR, and ARLEN SHALL hold stable until ARREADY is seen.
REQ-016 ARADDR for burst k = base_addr + k*stride, mod 2^ADDR_WIDTH (wrap silently). Bursts are never split; 4 KB compliance is the caller's responsibility.
REQ-017 ISSUE -> DRAIN on the AR handshake of the last burst. DRAIN -> DONE when outstanding == 0. DONE -> IDLE after 1 cycle.
REQ-018 Outstanding counter: +1 on an AR handshake; -1 on RVALID & RREADY & RLAST. If both occur in the same cycle, the counter is unchanged. The counter never exceeds MAX_OUTSTANDING.
REQ-019 RREADY is high whenever busy; the engine never back-pressures R.
REQ-020 Each R handshake produces read_data = RDATA and read_valid = 1 on the next cycle, with latency 1. read_data is 0 when read_valid = 0.
REQ-021 beat_count increments on every R handshake and saturates at its all-ones value.
REQ-022 RRESP of 10 or 11 sets err, which stays high until the next accepted start. The beat is still forwarded.
REQ-023 An R beat whose RID != ENGINE_ID sets err and is still counted.
REQ-024 done is a single-cycle pulse, asserted in DONE.

Reset
REQ-025 While resetn = 0: state = IDLE; ARVALID, RREADY, read_valid, busy, done, and err = 0; read_data, ARADDR, ARLEN, beat_count, and all counters = 0.
REQ-026 Reset mid-job SHALL abandon the job immediately with no further AR or R activity. Recovery of in-flight interconnect transactions belongs to the system reset.

Structure
REQ-027 Shared package axi_engine_pkg holds the RRESP codes, the AR constant field values, the ARSIZE-from-width function, and the FSM state enum.
REQ-028 One sub-module, rd_outstanding_ctr: parametrised up/down counter exposing a full flag, instantiated once.

Verification
REQ-029 Single job: base 0x1000, burst 7, num_bursts 1, ARREADY always 1 -> one AR with ARADDR 0x1000 and ARLEN 7; 8 read_valid pulses; done exactly 1 cycle after RLAST plus drain; beat_count 8.
REQ-030 Pipelining: num_bursts 10, stride 0x100, MAX_OUTSTANDING 4, R delayed 20 cycles -> exactly 4 ARs issued before the first RLAST; addresses run 0x1000..0x1900; beat_count 80.
REQ-031 AR back-pressure: ARREADY low for 5 cycles -> ARVALID and ARADDR stable throughout; no duplicate AR.
REQ-032 Error handling: RRESP 10 on beat 3 of burst 2 -> err rises the cycle after and stays high after done; all beats still delivered; next start clears err.
REQ-033 Boundaries: (a) num_bursts 0 -> done after 1 cycle with no AR. (b) base 0x1_FFFF_FF00 with stride 0x100 -> second ARADDR is 0. (c) start asserted while busy -> ignored. (d) resetn low mid-DRAIN -> all outputs 0 the next cycle.
